exec_writeback_stage: RTL and testbench
=======================================

Name: exec_writeback_stage

Overview:
Stage directly downstream of the combinational ALU. It registers ALU results and performs the data-memory access for opLW/opSW through a request/acknowledge handshake with a timeout. It drives the register-file write port. It holds the architectural FLAG and OVERFLOW registers, which feed back to the ALU FLAG_IN/OVERFLOW_IN.

Parameters:
REG_AW, 3, register-file address width
MEM_TIMEOUT, 15, maximum cycles MEM_REQ is held without MEM_ACK before abort (>=1)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
IN_VALID  input  1  upstream holds a valid instruction/ALU result
IN_READY  output  1  stage can accept this cycle
OP  input  3  opcode (op_mne encoding)
FUNC  input  3  O-type function field
DEST  input  REG_AW  destination register
ALU_OUT  input  8  ALU OUT (address for opLW/opSW)
ALU_FLAG  input  1  ALU FLAG_OUT
ALU_OVF  input  1  ALU OVERFLOW_OUT
STORE_DATA  input  8  register value to store for opSW
MEM_REQ  output  1  memory request
MEM_WE  output  1  1 = write, 0 = read; valid while MEM_REQ
MEM_ADDR  output  8  memory address
MEM_WDATA  output  8  store data
MEM_ACK  input  1  memory completes the request this cycle
MEM_RDATA  input  8  read data; valid with MEM_ACK
RF_WE  output  1  register-file write enable
RF_WADDR  output  REG_AW  write address
RF_WDATA  output  8  write data
FLAG_Q  output  1  architectural flag, to ALU FLAG_IN
OVERFLOW_Q  output  1  architectural overflow, to ALU OVERFLOW_IN
ERR_Q  output  1  sticky memory-timeout error

Behaviour:
- Reset (asynchronous, immediate, mid-operation included): state IDLE. All outputs 0 except IN_READY = 1. The counter clears. Any in-flight request is abandoned without an RF write.
- Acceptance: an instruction is accepted on an edge where IN_VALID && IN_READY. IN_READY = 1 only in IDLE. It is combinational from state.
- Single-cycle ops (opADD, opSUB, opSEI, O-type):
  - Accepted at edge N.
  - RF_WE = 1 for exactly one cycle after edge N, with RF_WADDR = DEST and RF_WDATA = ALU_OUT.
  - IN_READY stays 1, so back-to-back acceptance is allowed.
- Compare ops (opCEQ, opCLT): no RF write. FLAG_Q <= ALU_FLAG at the accept edge.
- Flag rules:
  - opADD, opSUB and all O-type ops set OVERFLOW_Q <= ALU_OVF at the accept edge.
  - No other op alters FLAG_Q or OVERFLOW_Q.
  - ALU_FLAG is ignored for all ops except compares.
  - Updated values are visible to the next instruction presented in the following cycle.
- Memory ops, FSM IDLE -> MEM -> (LOAD_WB) -> IDLE:
  - IDLE, accept opLW/opSW: capture DEST, ALU_OUT -> MEM_ADDR, STORE_DATA -> MEM_WDATA. MEM_WE = 1 for opSW. Clear the counter. Go to MEM.
  - MEM: MEM_REQ = 1; address, data and WE held stable. The counter increments each MEM cycle.
    - MEM_ACK: drop MEM_REQ at that edge. opLW: latch MEM_RDATA, go to LOAD_WB. opSW: go to IDLE.
    - Counter reaches MEM_TIMEOUT with no ACK: drop MEM_REQ, set ERR_Q. opLW: latch 8'h00, go to LOAD_WB. opSW: go to IDLE.
    - ACK in the same cycle as the timeout: ACK wins; ERR_Q unchanged.
  - LOAD_WB: RF_WE = 1 for one cycle with the latched data and DEST. Go to IDLE.
- Throughput: opSW with ACK in the first MEM cycle has IN_READY low for exactly 1 cycle; opLW has it low for 2.
- ERR_Q is cleared only by reset.
- MEM_ACK outside MEM is ignored.

Decomposition:
- Package definitions: the existing op_mne opcode enum and FUNC constants.
- Package definitions also gets a new wb_state_t enum {IDLE, MEM, LOAD_WB} and a helper function writes_rf(op) (true for opADD, opSUB, opSEI, O-type, opLW).
- No sub-module. The timeout counter is inline; its width is $clog2(MEM_TIMEOUT+1).

Test Plan:
- Reset mid-MEM (opLW pending): assert RESET_N=0 -> MEM_REQ drops the same cycle, no RF_WE, IN_READY=1, FLAG_Q=OVERFLOW_Q=ERR_Q=0.
- Back-to-back ALU ops:
  - Stimulus: opADD DEST=2 ALU_OUT=8'h05 ALU_OVF=1, then opCEQ ALU_FLAG=1.
  - Response: cycle after first accept RF_WE=1, RF_WADDR=2, RF_WDATA=8'h05, OVERFLOW_Q=1; next cycle FLAG_Q=1, RF_WE=0.
- Load with 3-cycle memory latency:
  - Stimulus: opLW ALU_OUT=8'h40 DEST=5; MEM_ACK on 3rd MEM cycle with MEM_RDATA=8'hA7.
  - Response: MEM_ADDR=8'h40, MEM_WE=0; then RF_WE=1 for one cycle, RF_WDATA=8'hA7, RF_WADDR=5; IN_READY low for 4 cycles total.
- Store with immediate ACK:
  - Stimulus: opSW ALU_OUT=8'h10 STORE_DATA=8'h3C.
  - Response: MEM_REQ=1, MEM_WE=1, MEM_WDATA=8'h3C for 1 cycle; no RF_WE; IN_READY=0 for 1 cycle.
- Timeout: MEM_TIMEOUT=15, opLW never acked -> MEM_REQ high exactly 15 cycles, ERR_Q=1 thereafter, RF_WDATA=8'h00 written.
- ACK on timeout cycle: MEM_ACK in the 15th MEM cycle with MEM_RDATA=8'h11 -> RF_WDATA=8'h11, ERR_Q stays 0.

Source files
------------

// File: rtl/exec_writeback_stage_pkg.sv
// exec_writeback_stage_pkg: opcode encoding, FUNC codes and writeback FSM states.
package exec_writeback_stage_pkg;
  typedef enum logic [2:0] {
    opADD = 3'd0,
    opSUB = 3'd1,
    opSEI = 3'd2,
    opCEQ = 3'd3,
    opCLT = 3'd4,
    opLW  = 3'd5,
    opSW  = 3'd6,
    opO   = 3'd7
  } op_mne;
  localparam logic [2:0] FN_AND = 3'd0;
  localparam logic [2:0] FN_OR  = 3'd1;
  localparam logic [2:0] FN_XOR = 3'd2;
  localparam logic [2:0] FN_NOT = 3'd3;
  localparam logic [2:0] FN_SHL = 3'd4;
  localparam logic [2:0] FN_SHR = 3'd5;
  localparam logic [2:0] FN_ROL = 3'd6;
  localparam logic [2:0] FN_ROR = 3'd7;
  typedef enum logic [1:0] {IDLE, MEM, LOAD_WB} wb_state_t;
  function automatic logic writes_rf(input logic [2:0] op);
    return op inside {opADD, opSUB, opSEI, opO, opLW};
  endfunction
endpackage

// File: rtl/exec_writeback_stage.sv
// exec_writeback_stage: registers ALU results, runs LW/SW memory handshake with timeout,
// drives the register-file write port and holds the architectural FLAG/OVERFLOW.
module exec_writeback_stage
  import exec_writeback_stage_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        OP,
  input  logic [2:0]        FUNC,
  input  logic [REG_AW-1:0] DEST,
  input  logic [7:0]        ALU_OUT,
  input  logic              ALU_FLAG,
  input  logic              ALU_OVF,
  input  logic [7:0]        STORE_DATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [7:0]        MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [7:0]        MEM_RDATA,
  output logic              RF_WE,
  output logic [REG_AW-1:0] RF_WADDR,
  output logic [7:0]        RF_WDATA,
  output logic              FLAG_Q,
  output logic              OVERFLOW_Q,
  output logic              ERR_Q
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  wb_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d, rf_we_q, rf_we_d, flag_q, flag_d, ovf_q, ovf_d, err_q, err_d;
  logic [7:0]        addr_q, addr_d, wdata_q, wdata_d, rf_wdata_q, rf_wdata_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic              accept, is_mem, timeout, unused_func;
  assign unused_func = ^FUNC;
  assign accept  = IN_VALID && state_q == IDLE;
  assign is_mem  = OP == opLW || OP == opSW;
  assign timeout = cnt_q == CW'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    flag_d     = flag_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (accept) begin
        rf_waddr_d = writes_rf(OP) ? DEST : rf_waddr_q;
        flag_d     = (OP == opCEQ || OP == opCLT) ? ALU_FLAG : flag_q;
        ovf_d      = (OP == opADD || OP == opSUB || OP == opO) ? ALU_OVF : ovf_q;
        if (is_mem) begin
          state_d = MEM;
          addr_d  = ALU_OUT;
          wdata_d = STORE_DATA;
          we_d    = OP == opSW;
          cnt_d   = '0;
        end else begin
          rf_we_d    = writes_rf(OP);
          rf_wdata_d = writes_rf(OP) ? ALU_OUT : rf_wdata_q;
        end
      end
      MEM: begin
        cnt_d = cnt_q + 1'b1;
        // ACK takes priority over a simultaneous timeout
        if (MEM_ACK || timeout) begin
          state_d    = we_q ? IDLE : LOAD_WB;
          rf_we_d    = !we_q;
          rf_wdata_d = we_q ? rf_wdata_q : (MEM_ACK ? MEM_RDATA : 8'h00);
          err_d      = err_q | !MEM_ACK;
          we_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flag_q     <= flag_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end
  assign IN_READY   = state_q == IDLE;
  assign MEM_REQ    = state_q == MEM;
  assign MEM_WE     = we_q && state_q == MEM;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign RF_WE      = rf_we_q;
  assign RF_WADDR   = rf_waddr_q;
  assign RF_WDATA   = rf_wdata_q;
  assign FLAG_Q     = flag_q;
  assign OVERFLOW_Q = ovf_q;
  assign ERR_Q      = err_q;
endmodule

// File: tb/tb_exec_writeback_stage.sv
// tb_exec_writeback_stage: directed checks of ALU writeback, flags, LW/SW handshake and timeout.
module tb_exec_writeback_stage;
  import exec_writeback_stage_pkg::*;
  logic       CLK = 1'b0, RESET_N = 1'b0, IN_VALID = 1'b0, IN_READY;
  logic [2:0] OP = 3'd0, FUNC = 3'd0, DEST = 3'd0, RF_WADDR;
  logic [7:0] ALU_OUT = 8'h00, STORE_DATA = 8'h00, MEM_RDATA = 8'h00;
  logic       ALU_FLAG = 1'b0, ALU_OVF = 1'b0, MEM_ACK = 1'b0;
  logic       MEM_REQ, MEM_WE, RF_WE, FLAG_Q, OVERFLOW_Q, ERR_Q;
  logic [7:0] MEM_ADDR, MEM_WDATA, RF_WDATA;
  int checks = 0, errors = 0, n;
  exec_writeback_stage #(.REG_AW(3), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .FUNC(FUNC), .DEST(DEST), .ALU_OUT(ALU_OUT), .ALU_FLAG(ALU_FLAG),
    .ALU_OVF(ALU_OVF), .STORE_DATA(STORE_DATA), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .FLAG_Q(FLAG_Q),
    .OVERFLOW_Q(OVERFLOW_Q), .ERR_Q(ERR_Q)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic present(input logic [2:0] op, input logic [2:0] d, input logic [7:0] a,
                         input logic f, input logic v, input logic [7:0] sd);
    IN_VALID = 1'b1; OP = op; DEST = d; ALU_OUT = a; ALU_FLAG = f; ALU_OVF = v; STORE_DATA = sd;
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ready", IN_READY, 1); chk("rst_req", MEM_REQ, 0); chk("rst_rfwe", RF_WE, 0);
    chk("rst_flag", FLAG_Q, 0); chk("rst_ovf", OVERFLOW_Q, 0); chk("rst_err", ERR_Q, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    present(opADD, 3'd2, 8'h05, 1'b0, 1'b1, 8'h00);
    @(negedge CLK);
    chk("add_rfwe", RF_WE, 1); chk("add_waddr", RF_WADDR, 2); chk("add_wdata", RF_WDATA, 8'h05);
    chk("add_ovf", OVERFLOW_Q, 1); chk("add_ready", IN_READY, 1);
    present(opCEQ, 3'd7, 8'hEE, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    chk("ceq_flag", FLAG_Q, 1); chk("ceq_rfwe", RF_WE, 0); chk("ceq_ovf_kept", OVERFLOW_Q, 1);
    present(opSEI, 3'd3, 8'h7F, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    chk("sei_rfwe", RF_WE, 1); chk("sei_wdata", RF_WDATA, 8'h7F); chk("sei_waddr", RF_WADDR, 3);
    chk("sei_flag_kept", FLAG_Q, 1); chk("sei_ovf_kept", OVERFLOW_Q, 1);
    present(opO, 3'd4, 8'h81, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    chk("o_ovf", OVERFLOW_Q, 0); chk("o_flag_kept", FLAG_Q, 1); chk("o_wdata", RF_WDATA, 8'h81);
    present(opLW, 3'd5, 8'h40, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    IN_VALID = 1'b0; ALU_OUT = 8'hFF;
    chk("lw_c1_req", MEM_REQ, 1); chk("lw_addr", MEM_ADDR, 8'h40); chk("lw_we", MEM_WE, 0);
    chk("lw_c1_ready", IN_READY, 0); chk("lw_c1_rfwe", RF_WE, 0);
    @(negedge CLK);
    chk("lw_c2_req", MEM_REQ, 1); chk("lw_c2_addr", MEM_ADDR, 8'h40); chk("lw_c2_ready", IN_READY, 0);
    @(negedge CLK);
    chk("lw_c3_req", MEM_REQ, 1); chk("lw_c3_ready", IN_READY, 0);
    MEM_ACK = 1'b1; MEM_RDATA = 8'hA7;
    @(negedge CLK);
    MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
    chk("lw_wb_req", MEM_REQ, 0); chk("lw_wb_rfwe", RF_WE, 1); chk("lw_wb_wdata", RF_WDATA, 8'hA7);
    chk("lw_wb_waddr", RF_WADDR, 5); chk("lw_wb_ready", IN_READY, 0);
    @(negedge CLK);
    chk("lw_done_rfwe", RF_WE, 0); chk("lw_done_ready", IN_READY, 1);
    present(opSW, 3'd1, 8'h10, 1'b0, 1'b0, 8'h3C);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("sw_req", MEM_REQ, 1); chk("sw_we", MEM_WE, 1); chk("sw_wdata", MEM_WDATA, 8'h3C);
    chk("sw_addr", MEM_ADDR, 8'h10); chk("sw_ready", IN_READY, 0); chk("sw_rfwe", RF_WE, 0);
    MEM_ACK = 1'b1;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("sw_done_req", MEM_REQ, 0); chk("sw_done_we", MEM_WE, 0);
    chk("sw_done_ready", IN_READY, 1); chk("sw_done_rfwe", RF_WE, 0);
    MEM_ACK = 1'b1; MEM_RDATA = 8'h55;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("idle_ack_rfwe", RF_WE, 0); chk("idle_ack_req", MEM_REQ, 0); chk("idle_ack_err", ERR_Q, 0);
    present(opLW, 3'd1, 8'h22, 1'b0, 1'b0, 8'h00);
    n = 0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    for (int i = 0; i < 40 && MEM_REQ; i++) begin
      n++;
      @(negedge CLK);
    end
    chk("to_req_cycles", 8'(n), 8'd15); chk("to_rfwe", RF_WE, 1);
    chk("to_wdata", RF_WDATA, 8'h00); chk("to_err", ERR_Q, 1);
    @(negedge CLK);
    chk("to_err_sticky", ERR_Q, 1); chk("to_ready", IN_READY, 1);
    present(opLW, 3'd2, 8'h30, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge CLK);
    IN_VALID = 1'b0;
    chk("mid_req_pre", MEM_REQ, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_req", MEM_REQ, 0); chk("mid_rst_rfwe", RF_WE, 0); chk("mid_rst_ready", IN_READY, 1);
    chk("mid_rst_flag", FLAG_Q, 0); chk("mid_rst_ovf", OVERFLOW_Q, 0); chk("mid_rst_err", ERR_Q, 0);
    @(negedge CLK);
    chk("mid_rst_hold_rfwe", RF_WE, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    present(opLW, 3'd6, 8'h33, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (14) @(negedge CLK);
    chk("ackto_c15_req", MEM_REQ, 1);
    MEM_ACK = 1'b1; MEM_RDATA = 8'h11;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("ackto_rfwe", RF_WE, 1); chk("ackto_wdata", RF_WDATA, 8'h11);
    chk("ackto_waddr", RF_WADDR, 6); chk("ackto_err", ERR_Q, 0);
    @(negedge CLK);
    chk("ackto_err_after", ERR_Q, 0); chk("ackto_ready", IN_READY, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
